// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/done handshake and operand/result bundle for
//               serial_subtractor. The ovf signal exists only when
//               SERSUB_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERSUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
`else
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Multi-cycle subtractor computing a - b - bin on WIDTH-bit
//               operands, CHUNK bits per clock, LSB chunk first, with a
//               registered borrow between chunks. Optional signed-overflow
//               output is enabled by defining SERSUB_OVF_EN.
//               The bus interface WIDTH must equal this module's WIDTH, and
//               WIDTH must be a multiple of CHUNK.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_subtractor_if.slave bus
);

  localparam int C_NCHUNK = WIDTH / CHUNK;
  localparam int C_CNT_W  = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_busy;
  logic   w_done;

  // The minuend register doubles as the result register: each cycle the
  // consumed low chunk of a is replaced by the difference chunk at the top,
  // so after NCHUNK shifts it holds the full result in order.
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_borrow;
  logic [C_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic [CHUNK:0]     w_sub;
  logic [WIDTH-1:0]   w_a_next;
  logic               w_accept;
  logic               w_last;

  // The top bit of the (CHUNK+1)-bit difference is the chunk borrow out.
  assign w_sub = {1'b0, r_a_sh[CHUNK-1:0]}
               - {1'b0, r_b_sh[CHUNK-1:0]}
               - {{CHUNK{1'b0}}, r_borrow};

  generate
    if (C_NCHUNK == 1) begin : g_single_chunk
      assign w_a_next = w_sub[CHUNK-1:0];
    end else begin : g_multi_chunk
      assign w_a_next = {w_sub[CHUNK-1:0], r_a_sh[WIDTH-1:CHUNK]};
    end
  endgenerate

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == C_LAST) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, chunk-serial subtraction and result capture on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= bus.a;
      r_b_sh   <= bus.b;
      r_borrow <= bus.bin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= w_a_next;
      r_b_sh   <= r_b_sh >> CHUNK;
      r_borrow <= w_sub[CHUNK];
      r_cnt    <= r_cnt + C_CNT_W'(1);
      if (w_last) begin
        r_diff <= w_a_next;
        r_bout <= w_sub[CHUNK];
      end
    end
  end

`ifdef SERSUB_OVF_EN
  // Operand sign bits are kept separately because the shift registers
  // consume them before the final chunk is computed.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Signed overflow: operands of opposite sign and a result whose sign differs from a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_a_next[WIDTH-1] != r_a_msb);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor with three
//               configurations: WIDTH=1/CHUNK=1, WIDTH=8/CHUNK=1 and
//               WIDTH=8/CHUNK=4. Overflow checks run when SERSUB_OVF_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(1)) if1 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(8)) if84 ();

  serial_subtractor #(.WIDTH(1), .CHUNK(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_subtractor #(.WIDTH(8), .CHUNK(1)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_subtractor #(.WIDTH(8), .CHUNK(4)) u_c4 (.clk(clk), .rst_n(rst_n), .bus(if84.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin);
    case (sel)
      0: begin if1.start = st; if1.a = ta[0]; if1.b = tb[0]; if1.bin = tbin; end
      1: begin if8.start = st; if8.a = ta; if8.b = tb; if8.bin = tbin; end
      default: begin if84.start = st; if84.a = ta; if84.b = tb; if84.bin = tbin; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return if1.done;
      1: return if8.done;
      default: return if84.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return if1.busy;
      1: return if8.busy;
      default: return if84.busy;
    endcase
  endfunction

  function automatic logic [7:0] get_diff(input int sel);
    case (sel)
      0: return {7'd0, if1.diff};
      1: return if8.diff;
      default: return if84.diff;
    endcase
  endfunction

  function automatic logic get_bout(input int sel);
    case (sel)
      0: return if1.bout;
      1: return if8.bout;
      default: return if84.bout;
    endcase
  endfunction

  // One operation: start for one cycle, scramble inputs after acceptance,
  // then check latency, busy length, result, single-cycle done and hold.
  task automatic op(input int sel, input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                    input logic [7:0] ediff, input logic ebout, input int elat, input string tag);
    int n;
    int nbusy;
    logic partial;
    logic [7:0] prev;
    @(negedge clk);
    prev = get_diff(sel);
    drive(sel, 1'b1, ta, tb, tbin);
    @(negedge clk);
    drive(sel, 1'b0, 8'hAA, 8'h55, ~tbin);
    n = 0;
    nbusy = 0;
    partial = 1'b0;
    while (!get_done(sel) && n < 64) begin
      if (get_busy(sel)) nbusy++;
      if (get_diff(sel) !== prev) partial = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, elat);
    chk({tag, ".busy_cycles"}, nbusy, elat);
    chk({tag, ".no_partial"}, {31'd0, partial}, 32'd0);
    chk({tag, ".diff"}, {24'd0, get_diff(sel)}, {24'd0, ediff});
    chk({tag, ".bout"}, {31'd0, get_bout(sel)}, {31'd0, ebout});
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, {31'd0, get_done(sel)}, 32'd0);
    chk({tag, ".diff_hold"}, {24'd0, get_diff(sel)}, {24'd0, ediff});
  endtask

  // Full-subtractor truth table indexed by {a, b, bin}.
  logic [7:0] w1_diff_tab = 8'b1001_0110;
  logic [7:0] w1_bout_tab = 8'b1000_1110;

  // Directed test sequence.
  initial begin
    int n;
    logic seen;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'd0, if8.busy}, 32'd0);
    chk("rst.done", {31'd0, if8.done}, 32'd0);
    chk("rst.diff", {24'd0, if8.diff}, 32'd0);
    chk("rst.bout", {31'd0, if8.bout}, 32'd0);
    chk("rst.w1_diff", {31'd0, if1.diff}, 32'd0);
`ifdef SERSUB_OVF_EN
    chk("rst.ovf", {31'd0, if8.ovf}, 32'd0);
`endif
    rst_n = 1'b1;

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = i[2:0];
      op(0, {7'd0, idx[2]}, {7'd0, idx[1]}, idx[0], {7'd0, w1_diff_tab[idx]}, w1_bout_tab[idx], 1,
         $sformatf("w1_%0d", i));
    end

    // WIDTH=8, CHUNK=1
    op(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 8, "w8_5m3");
    op(1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8, "w8_wrap");
    op(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8, "w8_0m1");
    op(1, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 8, "w8_max");

    // WIDTH=8, CHUNK=4
    op(2, 8'h3C, 8'hC3, 1'b1, 8'h78, 1'b1, 2, "c4_3c");
    op(2, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 2, "c4_a5");

`ifdef SERSUB_OVF_EN
    op(1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 8, "ovf_a");
    chk("ovf_a.ovf", {31'd0, if8.ovf}, 32'd1);
    op(1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 8, "ovf_b");
    chk("ovf_b.ovf", {31'd0, if8.ovf}, 32'd0);
`endif

    // start held high: back-to-back, new operands during RUN ignored
    @(negedge clk);
    drive(1, 1'b1, 8'h20, 8'h01, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 8'h40, 8'h02, 1'b1);
    n = 0;
    while (!if8.done && n < 64) begin @(negedge clk); n++; end
    chk("b2b1.latency", n, 8);
    chk("b2b1.diff", {24'd0, if8.diff}, 32'h1F);
    chk("b2b1.bout", {31'd0, if8.bout}, 32'd0);
    @(negedge clk);
    chk("b2b.idle_gap_busy", {31'd0, if8.busy}, 32'd0);
    chk("b2b.idle_gap_done", {31'd0, if8.done}, 32'd0);
    @(negedge clk);
    chk("b2b2.accepted", {31'd0, if8.busy}, 32'd1);
    drive(1, 1'b0, 8'h77, 8'h11, 1'b0);
    n = 0;
    while (!if8.done && n < 64) begin @(negedge clk); n++; end
    chk("b2b2.latency", n, 8);
    chk("b2b2.diff", {24'd0, if8.diff}, 32'h3D);
    chk("b2b2.bout", {31'd0, if8.bout}, 32'd0);
    repeat (3) @(negedge clk);
    chk("b2b.no_requeue", {31'd0, if8.busy}, 32'd0);

    // Reset asserted during RUN cycle 3
    drive(1, 1'b1, 8'h05, 8'h03, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 8'h05, 8'h03, 1'b0);
    chk("abort.running", {31'd0, if8.busy}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, if8.busy}, 32'd0);
    chk("abort.done", {31'd0, if8.done}, 32'd0);
    chk("abort.diff", {24'd0, if8.diff}, 32'd0);
    chk("abort.bout", {31'd0, if8.bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done || if8.busy) seen = 1'b1;
    end
    chk("abort.no_done", {31'd0, seen}, 32'd0);

    op(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor. Computes a - b - bin on WIDTH-bit operands, CHUNK bits per clock, with a registered borrow chain between chunks.
- Generalises the single-bit full-subtractor cell: start/done handshake, latched operands, borrow out and optional signed overflow.
- Sits in the arithmetic datapath wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CHUNK, 1, bits processed per cycle. WIDTH must be divisible by CHUNK. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request. Sampled only in IDLE.
- a  input  WIDTH  minuend. Latched when start is accepted.
- b  input  WIDTH  subtrahend. Latched when start is accepted.
- bin  input  1  borrow in. Latched when start is accepted.
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  result, registered
- bout  output  1  borrow out, registered
- ovf  output  1  signed overflow. Present only with SERSUB_OVF_EN.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow register and chunk counter cleared.
  - Reset asserted mid-operation aborts the operation with no done pulse. Outputs return to 0 immediately, not on a clock edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b and bin (bin into the borrow register), counter=0, go to RUN.
  - Otherwise hold. diff, bout and ovf keep the last result.
- RUN, one chunk per edge, LSB chunk first:
  - chunk difference = (a_chunk - b_chunk - borrow) mod 2^CHUNK.
  - New borrow = 1 iff a_chunk < b_chunk + borrow (unsigned).
  - Result chunk is shifted into the internal result register.
  - On the edge processing chunk NCHUNK-1: load diff from the internal register, set bout = final borrow, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- busy=1 exactly while state=RUN.
- Latency: start is sampled at edge E; diff, bout and done become valid after edge E+NCHUNK. Earliest next accepted start is edge E+NCHUNK+2.
- start is ignored while in RUN or DONE. It is not queued and latched operands are not disturbed.
- a, b and bin may change freely after acceptance.
- diff/bout change only on the completion edge. They never show partial results and hold until the next completion.
- Arithmetic contract:
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin (unsigned, WIDTH+1-bit compare).
- Wrap-around: a=0, b=0, bin=1 gives diff = all ones, bout=1.
- WIDTH=CHUNK is legal: single RUN cycle, NCHUNK=1.

Optional Feature:
- Macro: SERSUB_OVF_EN.
- Defined:
  - Port ovf exists, registered, updated on the same edge as diff.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using latched a and b.
  - bin does not enter the overflow formula beyond its effect on diff.
  - Reset value 0.
- Undefined: port ovf and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=1, CHUNK=1, all 8 combinations of a, b, bin -> diff/bout match the full-subtractor truth table. Example: a=0,b=1,bin=1 -> diff=0, bout=1. done 1 cycle after the start edge.
- WIDTH=8, CHUNK=1:
  - a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0. busy high 8 cycles; done pulses once after edge E+8.
  - a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
  - a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
- WIDTH=8, CHUNK=4: a=0x3C, b=0xC3, bin=1 -> diff=0x78, bout=1, done after edge E+2.
- WIDTH=8, SERSUB_OVF_EN defined: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x10, b=0x01 -> diff=0x0F, ovf=0.
- Protocol and reset:
  - start held high throughout -> operations are back-to-back, accepted only in IDLE.
  - New a/b presented during RUN -> result reflects the original operands.
  - rst_n pulsed low at RUN cycle 3 -> busy, done, diff and bout read 0 immediately; no done pulse follows.
